// File: rtl/rx_time_scheduler.sv
// Global emulation-time scheduler: picks the earliest pending edge among enabled
// clock generators and broadcasts it through a two-cycle latch/advance sequence.
module rx_time_scheduler #(
  parameter int N          = 4,
  parameter int TIME_WIDTH = 32,
  parameter int STEP_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N*TIME_WIDTH-1:0]   time_clock_in,
  input  logic [N-1:0]              en_mask,
  input  logic                      run,
  input  logic                      step_req,
  input  logic [STEP_WIDTH-1:0]     step_count,
  input  logic [TIME_WIDTH-1:0]     stop_time,
  output logic [TIME_WIDTH-1:0]     time_next,
  output logic                      tick,
  output logic [N-1:0]              fire,
  output logic                      busy,
  output logic                      done,
  output logic                      err_nonmono
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LATCH   = 2'd1,
    ST_ADVANCE = 2'd2
  } state_t;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  state_t                  state_r, state_s;
  logic                    mode_r, mode_s;
  logic [STEP_WIDTH-1:0]   cnt_r, cnt_s;
  logic [TIME_WIDTH-1:0]   time_next_r, time_next_s;
  logic [N-1:0]            fire_r, fire_s;
  logic                    tick_r, tick_s;
  logic                    busy_r, busy_s;
  logic                    done_r, done_s;
  logic                    err_r, err_s;

  logic                    min_valid_s;
  logic [TIME_WIDTH-1:0]   min_time_s;
  logic [N-1:0]            eq_mask_s;

  // Unsigned minimum over the enabled generators.
  always_comb begin
    min_valid_s = 1'b0;
    min_time_s  = {TIME_WIDTH{1'b1}};
    for (int i = 0; i < N; i++) begin
      if (en_mask[i] && (!min_valid_s || (time_clock_in[i*TIME_WIDTH +: TIME_WIDTH] < min_time_s))) begin
        min_valid_s = 1'b1;
        min_time_s  = time_clock_in[i*TIME_WIDTH +: TIME_WIDTH];
      end else begin
        min_time_s  = min_time_s;
      end
    end
  end

  // Every enabled generator sitting exactly at the minimum fires, so ties fire together.
  always_comb begin
    eq_mask_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      eq_mask_s[i] = en_mask[i] && min_valid_s &&
                     (time_clock_in[i*TIME_WIDTH +: TIME_WIDTH] == min_time_s);
    end
  end

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_s     = state_r;
    mode_s      = mode_r;
    cnt_s       = cnt_r;
    time_next_s = time_next_r;
    fire_s      = {N{1'b0}};
    tick_s      = 1'b0;
    done_s      = 1'b0;
    err_s       = err_r;
    case (state_r)
      ST_IDLE: begin
        if (step_req) begin
          cnt_s   = (step_count == {STEP_WIDTH{1'b0}}) ? STEP_WIDTH'(1) : step_count;
          mode_s  = MODE_STEP;
          state_s = ST_LATCH;
        end else if (run) begin
          mode_s  = MODE_RUN;
          state_s = ST_LATCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (!min_valid_s || (min_time_s > stop_time)) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          time_next_s = min_time_s;
          fire_s      = eq_mask_s;
          tick_s      = 1'b1;
          // Wrapped times are not special-cased; they show up here as non-monotonic.
          if (min_time_s < time_next_r) begin
            err_s = 1'b1;
          end else begin
            err_s = err_r;
          end
          state_s = ST_ADVANCE;
        end
      end
      ST_ADVANCE: begin
        if (mode_r == MODE_STEP) begin
          cnt_s = cnt_r - STEP_WIDTH'(1);
          if (cnt_r <= STEP_WIDTH'(1)) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            state_s = ST_LATCH;
          end
        end else if (run) begin
          state_s = ST_LATCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_RUN;
      cnt_r       <= {STEP_WIDTH{1'b0}};
      time_next_r <= {TIME_WIDTH{1'b0}};
      fire_r      <= {N{1'b0}};
      tick_r      <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      mode_r      <= mode_s;
      cnt_r       <= cnt_s;
      time_next_r <= time_next_s;
      fire_r      <= fire_s;
      tick_r      <= tick_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      err_r       <= err_s;
    end
  end

  assign time_next   = time_next_r;
  assign tick        = tick_r;
  assign fire        = fire_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err_nonmono = err_r;

endmodule

// File: tb/tb_rx_time_scheduler.sv
// Directed self-checking bench for rx_time_scheduler (N=4, 32-bit time).
module tb_rx_time_scheduler;

  localparam int N  = 4;
  localparam int TW = 32;
  localparam int SW = 16;
  localparam logic [TW-1:0] TMAX = 32'hFFFF_FFFF;

  logic            clk;
  logic            rst;
  logic [N*TW-1:0] time_clock_in;
  logic [N-1:0]    en_mask;
  logic            run;
  logic            step_req;
  logic [SW-1:0]   step_count;
  logic [TW-1:0]   stop_time;
  logic [TW-1:0]   time_next;
  logic            tick;
  logic [N-1:0]    fire;
  logic            busy;
  logic            done;
  logic            err_nonmono;

  int tests_run;
  int tests_failed;

  rx_time_scheduler #(.N(N), .TIME_WIDTH(TW), .STEP_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .time_clock_in(time_clock_in), .en_mask(en_mask),
    .run(run), .step_req(step_req), .step_count(step_count), .stop_time(stop_time),
    .time_next(time_next), .tick(tick), .fire(fire), .busy(busy), .done(done),
    .err_nonmono(err_nonmono)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_tc(input logic [TW-1:0] t0, input logic [TW-1:0] t1,
                        input logic [TW-1:0] t2, input logic [TW-1:0] t3);
    time_clock_in = {t3, t2, t1, t0};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    run = 1'b0;
    step_req = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    run = 1'b0;
    step_req = 1'b0;
    step_count = 16'd0;
    stop_time = TMAX;
    en_mask = 4'b0000;
    set_tc(TMAX, TMAX, TMAX, TMAX);
    cyc();
    cyc();
    check("rst_time_next", time_next, 32'd0);
    check("rst_tick", {31'd0, tick}, 32'd0);
    check("rst_fire", {28'd0, fire}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err_nonmono}, 32'd0);
    rst = 1'b0;

    // Free-run: first tick two cycles after run rises.
    set_tc(32'd100, 32'd250, TMAX, TMAX);
    en_mask = 4'b0011;
    run = 1'b1;
    cyc();
    check("run_c1_tick", {31'd0, tick}, 32'd0);
    check("run_c1_busy", {31'd0, busy}, 32'd1);
    cyc();
    check("run_c2_tick", {31'd0, tick}, 32'd1);
    check("run_c2_time", time_next, 32'd100);
    check("run_c2_fire", {28'd0, fire}, 32'd1);
    check("run_c2_busy", {31'd0, busy}, 32'd1);
    run = 1'b0;
    cyc();
    check("run_stop_tick", {31'd0, tick}, 32'd0);
    check("run_stop_busy", {31'd0, busy}, 32'd0);
    check("run_stop_done", {31'd0, done}, 32'd0);
    check("run_stop_hold", time_next, 32'd100);

    // Tie, with run dropped during LATCH.
    do_reset();
    set_tc(32'd40, 32'd40, 32'd90, 32'd40);
    en_mask = 4'b1111;
    run = 1'b1;
    cyc();
    run = 1'b0;
    cyc();
    check("tie_tick", {31'd0, tick}, 32'd1);
    check("tie_time", time_next, 32'd40);
    check("tie_fire", {28'd0, fire}, 32'd11);
    cyc();
    check("tie_idle_busy", {31'd0, busy}, 32'd0);
    check("tie_idle_tick", {31'd0, tick}, 32'd0);

    // Counted step of 3 with generators advancing by 10.
    do_reset();
    set_tc(32'd10, 32'd15, TMAX, TMAX);
    en_mask = 4'b0011;
    step_count = 16'd3;
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    check("step_c1_tick", {31'd0, tick}, 32'd0);
    cyc();
    check("step_e1_time", time_next, 32'd10);
    check("step_e1_fire", {28'd0, fire}, 32'd1);
    set_tc(32'd20, 32'd15, TMAX, TMAX);
    cyc();
    check("step_gap_tick", {31'd0, tick}, 32'd0);
    cyc();
    check("step_e2_time", time_next, 32'd15);
    check("step_e2_fire", {28'd0, fire}, 32'd2);
    set_tc(32'd20, 32'd25, TMAX, TMAX);
    cyc();
    cyc();
    check("step_e3_tick", {31'd0, tick}, 32'd1);
    check("step_e3_time", time_next, 32'd20);
    check("step_e3_done", {31'd0, done}, 32'd0);
    set_tc(32'd30, 32'd25, TMAX, TMAX);
    cyc();
    check("step_done", {31'd0, done}, 32'd1);
    check("step_done_tick", {31'd0, tick}, 32'd0);
    check("step_done_busy", {31'd0, busy}, 32'd0);
    check("step_hold", time_next, 32'd20);
    cyc();
    check("step_done_pulse", {31'd0, done}, 32'd0);
    check("step_idle_tick", {31'd0, tick}, 32'd0);

    // step_count of 0 issues exactly one event.
    step_count = 16'd0;
    step_req = 1'b1;
    cyc();
    step_req = 1'b0;
    cyc();
    check("step0_time", time_next, 32'd25);
    check("step0_tick", {31'd0, tick}, 32'd1);
    cyc();
    check("step0_done", {31'd0, done}, 32'd1);

    // stop_time: equal is issued, greater is not.
    do_reset();
    stop_time = 32'd500;
    set_tc(32'd500, 32'd600, TMAX, TMAX);
    en_mask = 4'b0011;
    run = 1'b1;
    cyc();
    cyc();
    check("stop_eq_time", time_next, 32'd500);
    check("stop_eq_tick", {31'd0, tick}, 32'd1);
    set_tc(32'd510, 32'd600, TMAX, TMAX);
    cyc();
    cyc();
    check("stop_done", {31'd0, done}, 32'd1);
    check("stop_tick", {31'd0, tick}, 32'd0);
    check("stop_busy", {31'd0, busy}, 32'd0);
    check("stop_hold", time_next, 32'd500);
    run = 1'b0;
    cyc();
    check("stop_done_pulse", {31'd0, done}, 32'd0);
    stop_time = TMAX;

    // Masking.
    do_reset();
    set_tc(32'd5, 32'd60, 32'd7, 32'd8);
    en_mask = 4'b0010;
    run = 1'b1;
    cyc();
    cyc();
    check("mask_time", time_next, 32'd60);
    check("mask_fire", {28'd0, fire}, 32'd2);
    run = 1'b0;
    cyc();
    en_mask = 4'b0000;
    run = 1'b1;
    cyc();
    run = 1'b0;
    check("mask0_busy", {31'd0, busy}, 32'd1);
    cyc();
    check("mask0_done", {31'd0, done}, 32'd1);
    check("mask0_tick", {31'd0, tick}, 32'd0);
    check("mask0_busy_end", {31'd0, busy}, 32'd0);

    // step_req while busy is ignored.
    do_reset();
    set_tc(32'd7, TMAX, TMAX, TMAX);
    en_mask = 4'b0001;
    run = 1'b1;
    cyc();
    step_count = 16'd1;
    step_req = 1'b1;
    run = 1'b0;
    cyc();
    step_req = 1'b0;
    cyc();
    check("busy_step_done", {31'd0, done}, 32'd0);
    check("busy_step_busy", {31'd0, busy}, 32'd0);

    // Non-monotonic minimum, then reset during LATCH.
    do_reset();
    set_tc(32'd200, TMAX, TMAX, TMAX);
    en_mask = 4'b0001;
    run = 1'b1;
    cyc();
    cyc();
    check("mono_t1", time_next, 32'd200);
    check("mono_err0", {31'd0, err_nonmono}, 32'd0);
    set_tc(32'd150, TMAX, TMAX, TMAX);
    cyc();
    cyc();
    check("mono_t2", time_next, 32'd150);
    check("mono_err1", {31'd0, err_nonmono}, 32'd1);
    run = 1'b0;
    cyc();
    check("mono_sticky", {31'd0, err_nonmono}, 32'd1);
    run = 1'b1;
    cyc();
    check("latch_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run = 1'b0;
    check("mid_rst_time", time_next, 32'd0);
    check("mid_rst_tick", {31'd0, tick}, 32'd0);
    check("mid_rst_fire", {28'd0, fire}, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_err", {31'd0, err_nonmono}, 32'd0);
    cyc();
    check("mid_rst_done", {31'd0, done}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
